// File: rtl/riscv_pkg.sv
// Shared definitions for the 5-stage RISC-V core: opcodes, ALU op encodings,
// the MUL stall FSM state type and operand-usage helpers for hazard detection.
package riscv_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_FUNCT  = 2'b10,
    ALU_MUL    = 2'b11
  } alu_op_e;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } mul_state_e;

  function automatic logic uses_rs1(input logic [6:0] opc);
    return (opc == OPC_R) || (opc == OPC_I) || (opc == OPC_BRANCH) ||
           (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OPC_R) || (opc == OPC_BRANCH) || (opc == OPC_STORE);
  endfunction

endpackage

// File: rtl/mul_stall_timer.sv
// Holds the front end while a multi-cycle MUL occupies EX. The first stall
// cycle is decided in RUN; MUL_WAIT then counts the remaining stall cycles.
module mul_stall_timer
  import riscv_pkg::*;
#(
  parameter int MUL_LATENCY = 4
) (
  input  logic clk,
  input  logic arst,
  input  logic ex_is_mul,
  output logic mul_stall
);

  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam bit MULTI = (MUL_LATENCY > 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0);

  mul_state_e       state;
  logic [CNT_W-1:0] mul_cnt;

  always_comb begin
    if (state == RUN) mul_stall = MULTI && ex_is_mul;
    else              mul_stall = (mul_cnt != '0);
  end

  // mul_cnt == 0 in MUL_WAIT is the release cycle: the MUL leaves EX at its end.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state   <= RUN;
      mul_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (MULTI && ex_is_mul) begin
            state   <= MUL_WAIT;
            mul_cnt <= CNT_LOAD;
          end
        end
        MUL_WAIT: begin
          if (mul_cnt != '0) mul_cnt <= mul_cnt - 1'b1;
          else               state   <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, branch/jump redirects and
// MUL freezes, prioritised into the front-end enables, plus a stall counter.
module hazard_stall_ctrl
  import riscv_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int REG_AW      = 5
) (
  input  logic              clk,
  input  logic              arst,
  input  logic [6:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              branch_taken,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_mul,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_write,
  output logic              id_ex_bubble,
  output logic              ex_mem_bubble,
  output logic              if_flush,
  output logic              mul_busy,
  output logic [31:0]       stall_cnt
);

  logic mul_stall;
  logic load_use;
  logic redirect;

  mul_stall_timer #(
    .MUL_LATENCY(MUL_LATENCY)
  ) u_mul_stall_timer (
    .clk       (clk),
    .arst      (arst),
    .ex_is_mul (ex_is_mul),
    .mul_stall (mul_stall)
  );

  always_comb begin
    load_use = ex_mem_read && (ex_rd != '0) &&
               ((uses_rs1(id_opcode) && (ex_rd == id_rs1)) ||
                (uses_rs2(id_opcode) && (ex_rd == id_rs2)));
    redirect = ((id_opcode == OPC_BRANCH) && branch_taken) || (id_opcode == OPC_JAL);
  end

  // A stalled branch is not flushed yet; its redirect is honoured once it can move.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    if_flush      = 1'b0;
    mul_busy      = 1'b0;
    if (mul_stall) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_bubble = 1'b1;
      mul_busy      = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (redirect) begin
      if_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst)           stall_cnt <= '0;
    else if (!pc_write) stall_cnt <= stall_cnt + 32'd1;
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: MUL_LATENCY 4 and 1 instances on shared inputs,
// checked every cycle against a MUL-age reference model of the stall rules.
module tb_hazard_stall_ctrl;
  import riscv_pkg::*;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_bubble;
    logic if_flush;
    logic mul_busy;
  } ctl_t;

  logic       clk = 1'b0;
  logic       arst;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       branch_taken, ex_mem_read, ex_is_mul;

  logic        pc_write_a, if_id_write_a, id_ex_write_a, id_ex_bubble_a;
  logic        ex_mem_bubble_a, if_flush_a, mul_busy_a;
  logic [31:0] stall_cnt_a;
  logic        pc_write_b, if_id_write_b, id_ex_write_b, id_ex_bubble_b;
  logic        ex_mem_bubble_b, if_flush_b, mul_busy_b;
  logic [31:0] stall_cnt_b;

  int          n_vec = 0;
  int          n_err = 0;
  int          age_a, age_b;
  logic [31:0] scnt_a, scnt_b;
  logic [31:0] snap;
  logic [6:0]  opc_tab [0:6];

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MUL_LATENCY(4), .REG_AW(5)) dut_a (
    .clk(clk), .arst(arst), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .branch_taken(branch_taken), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_is_mul(ex_is_mul), .pc_write(pc_write_a), .if_id_write(if_id_write_a),
    .id_ex_write(id_ex_write_a), .id_ex_bubble(id_ex_bubble_a),
    .ex_mem_bubble(ex_mem_bubble_a), .if_flush(if_flush_a), .mul_busy(mul_busy_a),
    .stall_cnt(stall_cnt_a)
  );

  hazard_stall_ctrl #(.MUL_LATENCY(1), .REG_AW(5)) dut_b (
    .clk(clk), .arst(arst), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .branch_taken(branch_taken), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_is_mul(ex_is_mul), .pc_write(pc_write_b), .if_id_write(if_id_write_b),
    .id_ex_write(id_ex_write_b), .id_ex_bubble(id_ex_bubble_b),
    .ex_mem_bubble(ex_mem_bubble_b), .if_flush(if_flush_b), .mul_busy(mul_busy_b),
    .stall_cnt(stall_cnt_b)
  );

  // age = number of cycles the current MUL has already spent in EX (0 = none)
  function automatic ctl_t ref_ctl(input int lat, input int age);
    ctl_t e;
    logic r1, r2, mstall, lu, redir;
    r1 = (id_opcode == OPC_R) || (id_opcode == OPC_I) || (id_opcode == OPC_BRANCH) ||
         (id_opcode == OPC_LOAD) || (id_opcode == OPC_STORE);
    r2 = (id_opcode == OPC_R) || (id_opcode == OPC_BRANCH) || (id_opcode == OPC_STORE);
    mstall = (age == 0) ? (ex_is_mul && lat > 1) : (age < lat - 1);
    lu = ex_mem_read && (ex_rd != 0) && ((r1 && ex_rd == id_rs1) || (r2 && ex_rd == id_rs2));
    redir = (id_opcode == OPC_BRANCH && branch_taken) || (id_opcode == OPC_JAL);
    e = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    if (mstall)     e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    else if (lu)    e = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    else if (redir) e.if_flush = 1'b1;
    return e;
  endfunction

  function automatic int next_age(input int lat, input int age);
    if (age == 0)          return (ex_is_mul && lat > 1) ? 1 : 0;
    else if (age >= lat-1) return 0;
    else                   return age + 1;
  endfunction

  task automatic model_reset();
    age_a = 0; age_b = 0; scnt_a = 0; scnt_b = 0;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check(input string tag);
    ctl_t oa, ob;
    oa = {pc_write_a, if_id_write_a, id_ex_write_a, id_ex_bubble_a,
          ex_mem_bubble_a, if_flush_a, mul_busy_a};
    ob = {pc_write_b, if_id_write_b, id_ex_write_b, id_ex_bubble_b,
          ex_mem_bubble_b, if_flush_b, mul_busy_b};
    cmp({tag, "/ctl_L4"}, 32'(oa), 32'(ref_ctl(4, age_a)));
    cmp({tag, "/ctl_L1"}, 32'(ob), 32'(ref_ctl(1, age_b)));
    cmp({tag, "/cnt_L4"}, stall_cnt_a, scnt_a);
    cmp({tag, "/cnt_L1"}, stall_cnt_b, scnt_b);
  endtask

  task automatic step(input string tag);
    ctl_t ea, eb;
    #1;
    check(tag);
    ea = ref_ctl(4, age_a);
    eb = ref_ctl(1, age_b);
    @(posedge clk);
    if (arst) begin
      model_reset();
    end else begin
      if (!ea.pc_write) scnt_a++;
      if (!eb.pc_write) scnt_b++;
      age_a = next_age(4, age_a);
      age_b = next_age(1, age_b);
    end
    #1;
  endtask

  task automatic set(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic tk, input logic mr, input logic [4:0] rd, input logic mul);
    id_opcode = op; id_rs1 = rs1; id_rs2 = rs2; branch_taken = tk;
    ex_mem_read = mr; ex_rd = rd; ex_is_mul = mul;
  endtask

  initial begin
    opc_tab[0] = OPC_R;    opc_tab[1] = OPC_I;     opc_tab[2] = OPC_BRANCH;
    opc_tab[3] = OPC_JAL;  opc_tab[4] = OPC_LOAD;  opc_tab[5] = OPC_STORE;
    opc_tab[6] = 7'b0110111;
    model_reset();
    arst = 1'b0;
    set(OPC_I, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0);
    #1 arst = 1'b1;
    step("reset0");
    step("reset1");
    arst = 1'b0;
    for (int i = 0; i < 8; i++) step("idle");

    // MUL in EX for MUL_LATENCY cycles with an ADD waiting in ID
    snap = stall_cnt_a;
    set(OPC_R, 5'd3, 5'd4, 1'b0, 1'b0, 5'd0, 1'b1);
    for (int i = 0; i < 4; i++) step("mul4");
    set(OPC_R, 5'd3, 5'd4, 1'b0, 1'b0, 5'd0, 1'b0);
    step("mul_after");
    cmp("mul_stall_delta", stall_cnt_a - snap, 32'd3);

    // load x5 in EX, ADD x6,x5,x1 in ID, then the load moves on
    set(OPC_R, 5'd5, 5'd1, 1'b0, 1'b1, 5'd5, 1'b0);
    step("load_use");
    set(OPC_R, 5'd5, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0);
    step("load_use_clear");
    set(OPC_R, 5'd0, 5'd1, 1'b0, 1'b1, 5'd0, 1'b0);
    step("load_x0");
    set(OPC_JAL, 5'd5, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0);
    step("jal_no_use");

    set(OPC_BRANCH, 5'd7, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0);
    step("beq_taken");
    set(OPC_BRANCH, 5'd7, 5'd8, 1'b0, 1'b0, 5'd0, 1'b0);
    step("beq_not_taken");
    set(OPC_JAL, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    step("jal");

    // MUL stall overlapping a taken BEQ: flush only in the release cycle
    set(OPC_BRANCH, 5'd7, 5'd8, 1'b1, 1'b0, 5'd0, 1'b1);
    for (int i = 0; i < 4; i++) step("mul_beq");
    set(OPC_I, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0);
    step("mul_beq_after");

    // branch depending on a load: stall first, redirect next cycle
    set(OPC_BRANCH, 5'd5, 5'd9, 1'b1, 1'b1, 5'd5, 1'b0);
    step("br_load_use");
    set(OPC_BRANCH, 5'd5, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0);
    step("br_redirect");

    // async reset in the second cycle of a MUL wait
    set(OPC_R, 5'd3, 5'd4, 1'b0, 1'b0, 5'd0, 1'b1);
    step("mul_pre_rst");
    #1 check("mul_wait2");
    arst = 1'b1;
    ex_is_mul = 1'b0;
    model_reset();
    #1 check("arst_mid_mul");
    cmp("arst_mul_busy", {31'd0, mul_busy_a}, 32'd0);
    step("arst_hold");
    arst = 1'b0;
    step("post_rst");

    // back-to-back MULs
    set(OPC_R, 5'd3, 5'd4, 1'b0, 1'b0, 5'd0, 1'b1);
    for (int i = 0; i < 8; i++) step("mul_b2b");
    set(OPC_I, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0);
    step("b2b_after");
    cmp("l1_never_stalled", stall_cnt_b, scnt_b);

    for (int i = 0; i < 400; i++) begin
      set(opc_tab[$urandom_range(0, 6)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
          ($urandom_range(0, 4) == 0));
      arst = ($urandom_range(0, 59) == 0);
      if (arst) model_reset();
      step("rand");
    end
    arst = 1'b0;
    step("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard and stall controller for the 5-stage RISC-V core. Sits beside the ID-stage control decoder and produces the PC/IF-ID/ID-EX write enables, bubble inserts and the IF flush. It detects load-use hazards and taken branches/jumps in ID, and sequences multi-cycle MUL operations in EX by freezing the front end for a parameterised number of cycles. It also keeps a free-running stall-cycle performance counter.

## Interface
- MUL_LATENCY, 4, EX-stage cycles a MUL occupies; legal range 1..16
- REG_AW, 5, register address width
- clk  in  1  core clock, all state on rising edge
- arst  in  1  asynchronous, active-high reset
- id_opcode  in  7  opcode of the instruction in ID
- id_rs1, id_rs2  in  REG_AW each  source registers of the instruction in ID
- branch_taken  in  1  branch comparison result in ID, valid when id_opcode is BRANCH
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  REG_AW  destination register of the instruction in EX
- ex_is_mul  in  1  instruction in EX is a MUL (alu_op == 2'b11)
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register enable
- id_ex_write  out  1  ID/EX register enable
- id_ex_bubble  out  1  load zero control into ID/EX
- ex_mem_bubble  out  1  load zero control into EX/MEM
- if_flush  out  1  squash the instruction in IF/ID
- mul_busy  out  1  a MUL stall is in progress this cycle
- stall_cnt  out  32  cycles with pc_write == 0 since reset; wraps at 2^32

## Operation
- FSM states: RUN, MUL_WAIT. Down-counter mul_cnt, width clog2(MUL_LATENCY).
- mul_stall = (RUN & ex_is_mul & MUL_LATENCY > 1) | (MUL_WAIT & mul_cnt != 0).
- RUN -> MUL_WAIT when ex_is_mul and MUL_LATENCY > 1; mul_cnt loads MUL_LATENCY-2.
- MUL_WAIT: mul_cnt decrements while nonzero; when mul_cnt == 0 there is no stall and the next state is RUN.
- uses_rs1 for opcodes R, I, BRANCH, LOAD, STORE; uses_rs2 for R, BRANCH, STORE; JAL uses neither.
- load_use = ex_mem_read & ex_rd != 0 & ((uses_rs1 & ex_rd == id_rs1) | (uses_rs2 & ex_rd == id_rs2)).
- redirect = (id_opcode == BRANCH & branch_taken) | id_opcode == JAL.
- Priority: mul_stall > load_use > redirect.
- mul_stall: pc_write = if_id_write = id_ex_write = 0, ex_mem_bubble = 1, id_ex_bubble = 0, if_flush = 0, mul_busy = 1.
- load_use (no mul_stall): pc_write = if_id_write = 0, id_ex_write = 1, id_ex_bubble = 1, if_flush = 0.
- redirect (no stall): if_flush = 1; all write enables 1.
- Otherwise all write enables are 1 and all bubbles and the flush are 0.
- stall_cnt increments in every cycle where pc_write == 0.

## Timing
- All outputs except stall_cnt are combinational from the state and the current inputs. The decision takes effect in the same cycle.
- A MUL that reaches EX at cycle T stalls cycles T..T+MUL_LATENCY-2 and advances to MEM at the edge ending cycle T+MUL_LATENCY-1.
- With MUL_LATENCY = 1 there is never a stall and MUL_WAIT is never entered.
- Back-to-back MULs: the second one enters EX in the cycle after the first one's release cycle and starts a fresh wait from RUN.
- A load-use stall lasts exactly 1 cycle. The next cycle, the load is in MEM and the hazard clears.
- A branch in ID that depends on a load in EX stalls first. Its redirect is honoured in the following cycle.
- Reset values: state = RUN, mul_cnt = 0, stall_cnt = 0. During reset, outputs follow the RUN equations.
- Asserting arst mid-MUL_WAIT drops mul_busy immediately and restores all write enables asynchronously.

## Structure
- Shared package riscv_pkg holds:
  - opcode constants: R 0110011, I 0010011, BRANCH 1100011, JAL 1101111, LOAD 0000011, STORE 0100011
  - ALUOp encodings
  - FSM state typedef
- One sub-module, mul_stall_timer, holds the FSM and mul_cnt, with inputs clk, arst, ex_is_mul and output mul_stall. Hazard detection and output muxing stay in the top.

## Test plan
- MUL_LATENCY = 4, MUL in EX at cycle 10 -> mul_busy and ex_mem_bubble are 1 in cycles 10–12, released in cycle 13; stall_cnt increases by 3.
- Load to x5 in EX with ADD x6,x5,x1 in ID -> exactly 1 cycle with pc_write = 0 and id_ex_bubble = 1. With ex_rd = x0 -> no stall.
- BEQ in ID with branch_taken = 1 and no hazard -> if_flush = 1 for 1 cycle. JAL in ID -> if_flush = 1 regardless of branch_taken.
- MUL stall and taken BEQ in ID at the same time -> if_flush = 0 until the MUL is released, then if_flush = 1 in the release cycle.
- arst pulsed in the second cycle of a MUL_LATENCY = 4 wait -> mul_busy falls immediately, stall_cnt = 0, and the FSM is back in RUN.
- MUL_LATENCY = 1 with two consecutive MULs -> mul_busy is never 1 and pc_write stays 1.
